// File: rtl/egress_pkt_buffer.sv
// egress_pkt_buffer: store-and-forward packet FIFO for one crossbar output port
// Ports:
//   iClk, iRst_n                    clock, asynchronous active-low reset
//   iInterMsg, iInterVld, oInterRdy crossbar input stream, payload is {EOP, data}
//   oTxData, oTxEop, oTxVld, iTxRdy head-of-FIFO word towards the Tx stage
//   oPktCnt, oWordCnt               complete packets stored, words stored
//   oFull, oEmpty                   occupancy status
//   oBypass                         oversize-packet cut-through mode is active
module egress_pkt_buffer #(
  parameter int DW = 32,
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic [DW:0]   iInterMsg,
  input  logic          iInterVld,
  output logic          oInterRdy,
  output logic [DW-1:0] oTxData,
  output logic          oTxEop,
  output logic          oTxVld,
  input  logic          iTxRdy,
  output logic [AW:0]   oPktCnt,
  output logic [AW:0]   oWordCnt,
  output logic          oFull,
  output logic          oEmpty,
  output logic          oBypass
);
  localparam logic [0:0] NORMAL = 1'b0;
  localparam logic [0:0] BYPASS = 1'b1;
  logic [DW:0] mem [DEPTH];
  logic [AW:0] wrPtr, rdPtr, pktCnt;
  logic [0:0] state;
  logic [DW:0] head;
  logic wrEn, rdEn, wrEop, rdEop;
  // pointer MSB is the wrap bit, so the difference is the exact occupancy 0..DEPTH
  assign oWordCnt = wrPtr - rdPtr;
  assign oFull = (wrPtr ^ rdPtr) == {1'b1, {AW{1'b0}}};
  assign oEmpty = wrPtr == rdPtr;
  assign oInterRdy = !oFull;
  assign oPktCnt = pktCnt;
  assign head = mem[rdPtr[AW-1:0]];
  assign oTxData = head[DW-1:0];
  assign oTxEop = head[DW];
  assign oBypass = state == BYPASS;
  // a word is releasable only once a whole packet is stored, unless cut-through is active
  assign oTxVld = !oEmpty && (pktCnt != '0 || oBypass);
  assign wrEn = iInterVld && oInterRdy;
  assign rdEn = oTxVld && iTxRdy;
  assign wrEop = wrEn && iInterMsg[DW];
  assign rdEop = rdEn && head[DW];
  always_ff @(posedge iClk)
    if (wrEn) mem[wrPtr[AW-1:0]] <= iInterMsg;
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      pktCnt <= '0;
      state <= NORMAL;
    end else begin
      wrPtr <= wrPtr + (AW+1)'(wrEn);
      rdPtr <= rdPtr + (AW+1)'(rdEn);
      pktCnt <= pktCnt + (AW+1)'(wrEop) - (AW+1)'(rdEop);
      // a full buffer holding no EOP can never complete a packet: stream it out cut-through
      state <= oBypass ? (rdEop ? NORMAL : BYPASS) : (oFull && pktCnt == '0 ? BYPASS : NORMAL);
    end
endmodule

// File: tb/tb_egress_pkt_buffer.sv
// tb_egress_pkt_buffer: vectors, corner sequences and random traffic against a queue model
module tb_egress_pkt_buffer;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int AW = $clog2(DEPTH);
  logic iClk, iRst_n, iInterVld, iTxRdy;
  logic [DW:0] iInterMsg;
  logic oInterRdy, oTxEop, oTxVld, oFull, oEmpty, oBypass;
  logic [DW-1:0] oTxData;
  logic [AW:0] oPktCnt, oWordCnt;
  int nChecks = 0, nFail = 0;
  logic [DW:0] q[$];
  logic [DW:0] rxQ[$];
  logic mByp = 0;
  logic accepted;

  egress_pkt_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iInterMsg(iInterMsg), .iInterVld(iInterVld),
    .oInterRdy(oInterRdy), .oTxData(oTxData), .oTxEop(oTxEop), .oTxVld(oTxVld),
    .iTxRdy(iTxRdy), .oPktCnt(oPktCnt), .oWordCnt(oWordCnt), .oFull(oFull),
    .oEmpty(oEmpty), .oBypass(oBypass)
  );

  initial iClk = 0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic vld, eop, rdy;
    logic [31:0] data;
    int wc, pc;
    logic txVld, txEop;
    logic [31:0] txData;
  } vec_t;
  vec_t vecs[20];

  function automatic vec_t mk(logic vld, logic eop, logic [31:0] data, logic rdy,
                              int wc, int pc, logic txVld, logic [31:0] txData, logic txEop);
    vec_t v;
    v.vld = vld; v.eop = eop; v.data = data; v.rdy = rdy;
    v.wc = wc; v.pc = pc; v.txVld = txVld; v.txData = txData; v.txEop = txEop;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eopCount();
    int n = 0;
    foreach (q[i]) n += int'(q[i][DW]);
    return n;
  endfunction

  function automatic logic modelVld();
    return q.size() > 0 && (eopCount() > 0 || mByp);
  endfunction

  // compares the DUT against the model, drives one cycle of stimulus and advances the model
  task automatic step(logic vld, logic eop, logic [31:0] data, logic rdy);
    logic wr, rd, nb;
    chk("wordCnt", 64'(oWordCnt), 64'(q.size()));
    chk("pktCnt", 64'(oPktCnt), 64'(eopCount()));
    chk("full", 64'(oFull), 64'(q.size() == DEPTH));
    chk("empty", 64'(oEmpty), 64'(q.size() == 0));
    chk("interRdy", 64'(oInterRdy), 64'(q.size() != DEPTH));
    chk("bypass", 64'(oBypass), 64'(mByp));
    chk("txVld", 64'(oTxVld), 64'(modelVld()));
    if (modelVld()) chk("txHead", 64'({oTxEop, oTxData}), 64'(q[0]));
    iInterVld = vld; iInterMsg = {eop, data}; iTxRdy = rdy;
    if (oTxVld && rdy) rxQ.push_back({oTxEop, oTxData});
    wr = vld && q.size() < DEPTH;
    rd = modelVld() && rdy;
    nb = mByp ? !(rd && q[0][DW]) : (q.size() == DEPTH && eopCount() == 0);
    if (rd) void'(q.pop_front());
    if (wr) q.push_back({eop, data});
    mByp = nb;
    accepted = wr;
    @(negedge iClk);
  endtask

  task automatic doReset();
    iRst_n = 0; iInterVld = 0; iTxRdy = 0; iInterMsg = '0;
    q.delete(); rxQ.delete(); mByp = 0;
    repeat (2) @(negedge iClk);
    iRst_n = 1;
  endtask

  initial begin
    int sent, cyc, guard;
    vecs[0]  = mk(1, 0, 32'hA0, 1, 1, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 32'hA1, 1, 2, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 32'hA2, 1, 3, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 32'hA3, 1, 4, 1, 1, 32'hA0, 0);
    vecs[4]  = mk(0, 0, 0,      1, 3, 1, 1, 32'hA1, 0);
    vecs[5]  = mk(0, 0, 0,      1, 2, 1, 1, 32'hA2, 0);
    vecs[6]  = mk(0, 0, 0,      1, 1, 1, 1, 32'hA3, 1);
    vecs[7]  = mk(0, 0, 0,      1, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 32'hB0, 0, 1, 0, 0, 0, 0);
    vecs[9]  = mk(1, 1, 32'hB1, 0, 2, 1, 1, 32'hB0, 0);
    vecs[10] = mk(1, 0, 32'hC0, 0, 3, 1, 1, 32'hB0, 0);
    vecs[11] = mk(1, 1, 32'hC1, 0, 4, 2, 1, 32'hB0, 0);
    vecs[12] = mk(1, 0, 32'hD0, 0, 5, 2, 1, 32'hB0, 0);
    vecs[13] = mk(1, 1, 32'hD1, 0, 6, 3, 1, 32'hB0, 0);
    vecs[14] = mk(0, 0, 0,      1, 5, 3, 1, 32'hB1, 1);
    vecs[15] = mk(0, 0, 0,      1, 4, 2, 1, 32'hC0, 0);
    vecs[16] = mk(0, 0, 0,      1, 3, 2, 1, 32'hC1, 1);
    vecs[17] = mk(0, 0, 0,      1, 2, 1, 1, 32'hD0, 0);
    vecs[18] = mk(0, 0, 0,      1, 1, 1, 1, 32'hD1, 1);
    vecs[19] = mk(0, 0, 0,      1, 0, 0, 0, 0, 0);
    iRst_n = 0; iInterVld = 0; iTxRdy = 0; iInterMsg = '0;
    repeat (2) @(negedge iClk);
    chk("rstWordCnt", 64'(oWordCnt), 0);
    chk("rstPktCnt", 64'(oPktCnt), 0);
    chk("rstInterRdy", 64'(oInterRdy), 1);
    chk("rstTxVld", 64'(oTxVld), 0);
    chk("rstEmpty", 64'(oEmpty), 1);
    chk("rstFull", 64'(oFull), 0);
    chk("rstBypass", 64'(oBypass), 0);
    iRst_n = 1;
    @(negedge iClk);
    foreach (vecs[i]) begin
      step(vecs[i].vld, vecs[i].eop, vecs[i].data, vecs[i].rdy);
      chk($sformatf("vec%0d.wordCnt", i), 64'(oWordCnt), 64'(vecs[i].wc));
      chk($sformatf("vec%0d.pktCnt", i), 64'(oPktCnt), 64'(vecs[i].pc));
      chk($sformatf("vec%0d.txVld", i), 64'(oTxVld), 64'(vecs[i].txVld));
      if (vecs[i].txVld) chk($sformatf("vec%0d.txHead", i), 64'({oTxEop, oTxData}),
                             64'({vecs[i].txEop, vecs[i].txData}));
    end
    // oversize packet: fill without EOP, enter cut-through, finish with EOP on word 9
    doReset();
    @(negedge iClk);
    for (int i = 0; i < 8; i++) step(1, 0, 32'hE0 + i, 0);
    chk("ovFull", 64'(oFull), 1);
    chk("ovInterRdy", 64'(oInterRdy), 0);
    step(0, 0, 0, 0);
    chk("ovBypass", 64'(oBypass), 1);
    chk("ovTxVld", 64'(oTxVld), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("ovBypassMid", 64'(oBypass), 1);
    step(1, 1, 32'hE8, 0);
    guard = 0;
    while (oWordCnt != 0 && guard < 20) begin step(0, 0, 0, 1); guard++; end
    chk("ovDrained", 64'(oWordCnt), 0);
    chk("ovBypassClr", 64'(oBypass), 0);
    chk("ovRxCount", 64'(rxQ.size()), 9);
    for (int i = 0; i < 9 && i < rxQ.size(); i++)
      chk($sformatf("ovRx%0d", i), 64'(rxQ[i]), 64'({i == 8, 32'hE0 + i}));
    // simultaneous EOP read and EOP write, wrapping pointers over 3*DEPTH words
    step(1, 1, 32'h100, 0);
    for (int i = 1; i <= 3 * DEPTH + 2; i++) begin
      step(1, 1, 32'h100 + i, 1);
      chk("simWordCnt", 64'(oWordCnt), 1);
      chk("simPktCnt", 64'(oPktCnt), 1);
    end
    step(0, 0, 0, 1);
    chk("simDrained", 64'(oEmpty), 1);
    // asynchronous reset with an unfinished packet stored
    for (int i = 0; i < 5; i++) step(1, 0, 32'h200 + i, 0);
    chk("preRstWordCnt", 64'(oWordCnt), 5);
    #2 iRst_n = 0;
    #1;
    chk("arstWordCnt", 64'(oWordCnt), 0);
    chk("arstPktCnt", 64'(oPktCnt), 0);
    chk("arstTxVld", 64'(oTxVld), 0);
    chk("arstInterRdy", 64'(oInterRdy), 1);
    chk("arstEmpty", 64'(oEmpty), 1);
    doReset();
    @(negedge iClk);
    // random traffic
    sent = 0; cyc = 0;
    while (sent < 10000 && cyc < 60000) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 2) != 0);
      if (accepted) sent++;
      cyc++;
    end
    chk("rndBudget", 64'(sent >= 10000), 1);
    guard = 0;
    accepted = 0;
    while (!accepted && guard < 100) begin step(1, 1, 32'hFEED, 1); guard++; end
    guard = 0;
    while (q.size() != 0 && guard < 200) begin step(0, 0, 0, 1); guard++; end
    step(0, 0, 0, 0);
    chk("rndDrained", 64'(oEmpty), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
